lsu_bus_if: RTL and testbench
=============================

Name: lsu_bus_if

Overview:
- Load/store unit between the single-cycle core's data port (ALUResult/WriteData/MemWrite/ReadData) and a multi-cycle data memory with a req/ack handshake.
- Adds byte/halfword access (LB/LH/LW/LBU/LHU/SB/SH/SW): byte-lane steering, byte enables and load sign/zero extension.
- Holds the core with a stall while the memory transaction is outstanding.
- Detects misaligned accesses, illegal funct3 encodings and bus timeouts.

Parameters:
- TIMEOUT, 64, max cycles in REQ waiting for mem_ack before aborting with fault; legal range 1..255.

Ports:
- clk  in  1  single clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- req_valid  in  1  core requests a load or store this cycle; held stable with all req_* while stall=1.
- req_write  in  1  1=store, 0=load.
- req_funct3  in  3  RISC-V funct3 size/sign code.
- req_addr  in  32  byte address.
- req_wdata  in  32  store data, right-justified.
- stall  out  1  core must not advance PC or commit.
- rdata  out  32  extended load result; valid when req_valid=1 & stall=0 & req_write=0.
- fault  out  1  one-cycle pulse: misaligned, illegal funct3, or timeout.
- mem_req  out  1  memory request, held until ack.
- mem_we  out  1  write strobe.
- mem_be  out  4  byte enables.
- mem_addr  out  32  word-aligned address, {req_addr[31:2],2'b00}.
- mem_wdata  out  32  lane-steered store data.
- mem_ack  in  1  memory completes the request this cycle.
- mem_rdata  in  32  read word, valid with mem_ack.

Behaviour:
- States: IDLE, REQ, DONE. Reset, synchronous: state=IDLE. Outputs in reset: mem_req=0, mem_we=0, mem_be=0, fault=0, rdata=0, timeout counter=0.
- stall is combinational: stall = req_valid & ~(state==DONE) & ~bad.
  - bad = misaligned or illegal funct3.
  - Misaligned: halfword with addr[0]=1, or word with addr[1:0]!=0.
  - Illegal funct3: 011, 110, 111; for stores, also anything other than 000/001/010.
- IDLE:
  - req_valid & ~bad: latch be, wdata and funct3; go to REQ.
  - req_valid & bad: fault=1 this cycle, stall=0, rdata=0; no memory access; stay in IDLE.
- REQ:
  - mem_req=1; mem_we, mem_be, mem_addr and mem_wdata driven from the latched values and stable until ack.
  - mem_ack=1: capture the extended mem_rdata into the rdata register; go to DONE.
  - Timeout counter increments each REQ cycle without ack. When it reaches TIMEOUT: drop mem_req, pulse fault, load rdata=0, go to DONE.
- DONE: mem_req=0, stall=0, rdata held. Next state is IDLE unconditionally.
- Minimum latency with ack on the first REQ cycle: stall high for 2 cycles, low on the 3rd (DONE). A back-to-back request starts in the following IDLE cycle.
- mem_ack outside REQ is ignored.
- Byte enables:
  - SB/LB/LBU: 4'b0001<<addr[1:0].
  - SH/LH/LHU: addr[1] ? 4'b1100 : 4'b0011.
  - SW/LW: 4'b1111.
- Store data:
  - SB: byte replicated to all 4 lanes.
  - SH: halfword replicated to both halves.
  - SW: passed through.
- Load extraction: select the lane by addr[1:0]. LB/LH sign-extend; LBU/LHU zero-extend; LW passes through.
- Reset asserted in REQ: state returns to IDLE and mem_req is 0 on the next cycle. A pending ack is discarded and no fault is raised.
- req_valid dropping mid-transaction is a protocol violation: the transaction still completes and the result is discarded.

Test Plan:
- LW, addr 0x64, mem_ack on the first REQ cycle, mem_rdata 0x8000_0019 -> mem_be=1111, stall high for 2 cycles, rdata=0x8000_0019 in DONE.
- LB, addr 0x63, mem_rdata 0x80FF_1234 -> mem_be=1000, rdata=0xFFFF_FF80. LBU at the same address -> rdata=0x0000_0080.
- SH, addr 0x62, req_wdata 0xDEAD_BEEF, ack after 3 wait cycles -> mem_we=1, mem_be=1100, mem_wdata=0xBEEF_BEEF stable for all 4 REQ cycles, stall low on the following DONE cycle.
- LW at addr 0x66 -> fault=1 same cycle, stall=0, mem_req never asserted. SB with funct3=011 also faults.
- TIMEOUT=4, mem_ack never asserted -> mem_req high exactly 4 cycles, then fault pulses with rdata=0 and stall drops in DONE.
- Reset asserted during REQ, then mem_ack pulses the cycle after reset deasserts -> mem_req=0, state IDLE, no rdata update, no fault.

Source files
------------

// File: rtl/lsu_bus_if.sv
// Load/store unit bridging the core's single-cycle data port to a multi-cycle
// req/ack data memory. Handles byte/halfword lane steering, load extension,
// stalls the core while a transaction is outstanding, and flags misaligned
// accesses, illegal funct3 codes and bus timeouts with a one-cycle fault.
module lsu_bus_if #(
  parameter int TIMEOUT = 64
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  input  logic        req_write,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        stall,
  output logic [31:0] rdata,
  output logic        fault,
  output logic        mem_req,
  output logic        mem_we,
  output logic [3:0]  mem_be,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [7:0] TMO_LAST = 8'(TIMEOUT - 1);

  state_t      state;
  state_t      state_next;

  logic        misaligned;
  logic        illegal;
  logic        bad;
  logic        reject;
  logic [3:0]  be_calc;
  logic [31:0] wdata_calc;
  logic [31:0] lane_word;
  logic [31:0] load_ext;

  logic        start;
  logic        ack_take;
  logic        timeout_hit;

  logic        we_q;
  logic [3:0]  be_q;
  logic [2:0]  funct3_q;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic [7:0]  tmo_cnt;
  logic [31:0] rdata_q;
  logic        fault_q;

  // Classify the incoming request: size/alignment check and legal funct3 set
  always_comb begin
    misaligned = 1'b0;
    illegal    = 1'b0;
    case (req_funct3)
      3'b000, 3'b100: misaligned = 1'b0;
      3'b001, 3'b101: misaligned = req_addr[0];
      3'b010:         misaligned = (req_addr[1:0] != 2'b00);
      default:        illegal    = 1'b1;
    endcase
    if (req_write && (req_funct3 > 3'b010)) begin
      illegal = 1'b1;
    end
  end

  assign bad    = misaligned | illegal;
  assign reject = (state == IDLE) & req_valid & bad;

  // Byte enables and lane-replicated store data for the request being accepted
  always_comb begin
    be_calc    = 4'b1111;
    wdata_calc = req_wdata;
    case (req_funct3[1:0])
      2'b00: begin
        be_calc    = 4'b0001 << req_addr[1:0];
        wdata_calc = {4{req_wdata[7:0]}};
      end
      2'b01: begin
        be_calc    = req_addr[1] ? 4'b1100 : 4'b0011;
        wdata_calc = {2{req_wdata[15:0]}};
      end
      default: begin
        be_calc    = 4'b1111;
        wdata_calc = req_wdata;
      end
    endcase
  end

  // Shift the addressed lane down and sign/zero extend according to funct3
  always_comb begin
    lane_word = mem_rdata >> {addr_q[1:0], 3'b000};
    load_ext  = mem_rdata;
    case (funct3_q)
      3'b000:  load_ext = {{24{lane_word[7]}}, lane_word[7:0]};
      3'b100:  load_ext = {24'd0, lane_word[7:0]};
      3'b001:  load_ext = {{16{lane_word[15]}}, lane_word[15:0]};
      3'b101:  load_ext = {16'd0, lane_word[15:0]};
      default: load_ext = mem_rdata;
    endcase
  end

  // Next-state logic; ack takes priority over a timeout in the same cycle
  always_comb begin
    state_next  = state;
    start       = 1'b0;
    ack_take    = 1'b0;
    timeout_hit = 1'b0;
    case (state)
      IDLE: begin
        if (req_valid && !bad) begin
          start      = 1'b1;
          state_next = REQ;
        end
      end
      REQ: begin
        if (mem_ack) begin
          ack_take   = 1'b1;
          state_next = DONE;
        end else if (tmo_cnt == TMO_LAST) begin
          timeout_hit = 1'b1;
          state_next  = DONE;
        end
      end
      DONE: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Latched request, timeout counter, load result and registered timeout fault
  always_ff @(posedge clk) begin
    if (reset) begin
      we_q     <= 1'b0;
      be_q     <= 4'b0000;
      funct3_q <= 3'b000;
      addr_q   <= 32'd0;
      wdata_q  <= 32'd0;
      tmo_cnt  <= 8'd0;
      rdata_q  <= 32'd0;
      fault_q  <= 1'b0;
    end else begin
      fault_q <= timeout_hit;
      if (start) begin
        we_q     <= req_write;
        be_q     <= be_calc;
        funct3_q <= req_funct3;
        addr_q   <= req_addr;
        wdata_q  <= wdata_calc;
        tmo_cnt  <= 8'd0;
      end else if (state == REQ && !mem_ack) begin
        tmo_cnt <= tmo_cnt + 8'd1;
      end
      if (ack_take) begin
        rdata_q <= load_ext;
      end else if (timeout_hit) begin
        rdata_q <= 32'd0;
      end
    end
  end

  assign stall     = req_valid & (state != DONE) & ~bad;
  assign fault     = ~reset & (fault_q | reject);
  assign rdata     = reject ? 32'd0 : rdata_q;
  assign mem_req   = (state == REQ);
  assign mem_we    = (state == REQ) & we_q;
  assign mem_be    = (state == REQ) ? be_q : 4'b0000;
  assign mem_addr  = {addr_q[31:2], 2'b00};
  assign mem_wdata = wdata_q;

endmodule

// File: tb/tb_lsu_bus_if.sv
// Directed self-checking bench for lsu_bus_if with a small memory-side driver
// and a scoreboard of expected load results / faults per transaction.
module tb_lsu_bus_if;

  localparam int TMO = 4;

  logic        clk;
  logic        reset;
  logic        req_valid;
  logic        req_write;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        stall;
  logic [31:0] rdata;
  logic        fault;
  logic        mem_req;
  logic        mem_we;
  logic [3:0]  mem_be;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_ack;
  logic [31:0] mem_rdata;

  typedef struct {
    string       tag;
    logic [31:0] rdata;
    logic        fault;
    logic        chk_rdata;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  lsu_bus_if #(.TIMEOUT(TMO)) dut (
    .clk       (clk),
    .reset     (reset),
    .req_valid (req_valid),
    .req_write (req_write),
    .req_funct3(req_funct3),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .stall     (stall),
    .rdata     (rdata),
    .fault     (fault),
    .mem_req   (mem_req),
    .mem_we    (mem_we),
    .mem_be    (mem_be),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_ack   (mem_ack),
    .mem_rdata (mem_rdata)
  );

  // Free-running clock, 10 time units per cycle
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Reference: does this request get rejected outright
  function automatic logic model_bad(logic w, logic [2:0] f, logic [31:0] a);
    if (w && (f != 3'b000) && (f != 3'b001) && (f != 3'b010)) return 1'b1;
    case (f)
      3'b000, 3'b100: return 1'b0;
      3'b001, 3'b101: return a[0];
      3'b010:         return (a[1] | a[0]);
      default:        return 1'b1;
    endcase
  endfunction

  // Reference byte enables
  function automatic logic [3:0] model_be(logic [2:0] f, logic [31:0] a);
    if (f[1:0] == 2'b00) begin
      case (a[1:0])
        2'd0:    return 4'b0001;
        2'd1:    return 4'b0010;
        2'd2:    return 4'b0100;
        default: return 4'b1000;
      endcase
    end
    if (f[1:0] == 2'b01) return a[1] ? 4'b1100 : 4'b0011;
    return 4'b1111;
  endfunction

  // Reference replicated store data
  function automatic logic [31:0] model_wdata(logic [2:0] f, logic [31:0] d);
    if (f[1:0] == 2'b00) return {d[7:0], d[7:0], d[7:0], d[7:0]};
    if (f[1:0] == 2'b01) return {d[15:0], d[15:0]};
    return d;
  endfunction

  // Reference load extraction and extension
  function automatic logic [31:0] model_load(logic [2:0] f, logic [31:0] a, logic [31:0] word);
    logic [7:0]  b;
    logic [15:0] h;
    case (a[1:0])
      2'd0:    b = word[7:0];
      2'd1:    b = word[15:8];
      2'd2:    b = word[23:16];
      default: b = word[31:24];
    endcase
    h = a[1] ? word[31:16] : word[15:0];
    case (f)
      3'b000:  return {{24{b[7]}}, b};
      3'b100:  return {24'd0, b};
      3'b001:  return {{16{h[15]}}, h};
      3'b101:  return {16'd0, h};
      default: return word;
    endcase
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Pop the scoreboard entry for a finished transaction and compare it
  task automatic checkOutput();
    exp_t e;
    if (sb.size() == 0) begin
      check("sb_empty", 32'd1, 32'd0);
      return;
    end
    e = sb.pop_front();
    check({e.tag, "_fault"}, {31'd0, fault}, {31'd0, e.fault});
    if (e.chk_rdata) check({e.tag, "_rdata"}, rdata, e.rdata);
  endtask

  // Drive one request and act as the memory; ack_delay < 0 means never ack
  task automatic applyStimulus(input string tag, input logic w, input logic [2:0] f,
                               input logic [31:0] a, input logic [31:0] wd,
                               input logic [31:0] rd, input int ack_delay);
    exp_t e;
    logic bad;
    int   stall_cnt = 0;
    int   req_cnt = 0;
    logic done = 1'b0;
    bad         = model_bad(w, f, a);
    e.tag       = tag;
    e.fault     = bad || (ack_delay < 0);
    e.rdata     = (bad || ack_delay < 0) ? 32'd0 : model_load(f, a, rd);
    e.chk_rdata = bad || !w;
    sb.push_back(e);

    @(negedge clk);
    req_valid  = 1'b1;
    req_write  = w;
    req_funct3 = f;
    req_addr   = a;
    req_wdata  = wd;
    mem_rdata  = rd;
    mem_ack    = 1'b0;
    #1;
    for (int cyc = 0; cyc < 40; cyc++) begin
      if (!stall) begin
        check({tag, "_req_at_end"}, {31'd0, mem_req}, 32'd0);
        checkOutput();
        done = 1'b1;
        break;
      end
      stall_cnt++;
      check({tag, "_fault_while_busy"}, {31'd0, fault}, 32'd0);
      if (mem_req) begin
        req_cnt++;
        check({tag, "_be"}, {28'd0, mem_be}, {28'd0, model_be(f, a)});
        check({tag, "_we"}, {31'd0, mem_we}, {31'd0, w});
        check({tag, "_addr"}, mem_addr, {a[31:2], 2'b00});
        if (w) check({tag, "_wdata"}, mem_wdata, model_wdata(f, wd));
        mem_ack = (ack_delay >= 0) && (req_cnt == ack_delay + 1);
      end else begin
        mem_ack = 1'b0;
      end
      @(negedge clk);
      #1;
    end
    if (!done) begin
      check({tag, "_bound"}, 32'd0, 32'd1);
      void'(sb.pop_front());
    end
    check({tag, "_stall_cycles"}, stall_cnt,
          bad ? 0 : (ack_delay < 0 ? TMO + 1 : ack_delay + 2));
    check({tag, "_req_cycles"}, req_cnt,
          bad ? 0 : (ack_delay < 0 ? TMO : ack_delay + 1));
    req_valid = 1'b0;
    mem_ack   = 1'b0;
  endtask

  // Directed sequence
  initial begin
    reset      = 1'b1;
    req_valid  = 1'b0;
    req_write  = 1'b0;
    req_funct3 = 3'b000;
    req_addr   = 32'd0;
    req_wdata  = 32'd0;
    mem_ack    = 1'b0;
    mem_rdata  = 32'd0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_mem_req", {31'd0, mem_req}, 32'd0);
    check("rst_mem_we",  {31'd0, mem_we}, 32'd0);
    check("rst_mem_be",  {28'd0, mem_be}, 32'd0);
    check("rst_fault",   {31'd0, fault}, 32'd0);
    check("rst_rdata",   rdata, 32'd0);
    check("rst_stall",   {31'd0, stall}, 32'd0);
    reset = 1'b0;

    applyStimulus("lw_64",     1'b0, 3'b010, 32'h64, 32'h0, 32'h8000_0019, 0);
    check("lw_64_rdata_lit", rdata, 32'h8000_0019);
    applyStimulus("lb_63",     1'b0, 3'b000, 32'h63, 32'h0, 32'h80FF_1234, 0);
    check("lb_63_rdata_lit", rdata, 32'hFFFF_FF80);
    applyStimulus("lbu_63",    1'b0, 3'b100, 32'h63, 32'h0, 32'h80FF_1234, 0);
    check("lbu_63_rdata_lit", rdata, 32'h0000_0080);
    applyStimulus("sh_62",     1'b1, 3'b001, 32'h62, 32'hDEAD_BEEF, 32'h0, 3);
    applyStimulus("lw_66_mis", 1'b0, 3'b010, 32'h66, 32'h0, 32'h1234_5678, 0);
    applyStimulus("sb_f011",   1'b1, 3'b011, 32'h40, 32'h55, 32'h0, 0);
    applyStimulus("lw_tmo",    1'b0, 3'b010, 32'h10, 32'h0, 32'hFFFF_FFFF, -1);
    applyStimulus("lh_62",     1'b0, 3'b001, 32'h62, 32'h0, 32'h8001_7FFF, 1);
    applyStimulus("lhu_60",    1'b0, 3'b101, 32'h60, 32'h0, 32'h8001_7FFF, 0);
    applyStimulus("sb_61",     1'b1, 3'b000, 32'h61, 32'h1234_56A5, 32'h0, 2);
    applyStimulus("sw_70",     1'b1, 3'b010, 32'h70, 32'hCAFE_F00D, 32'h0, 1);
    applyStimulus("ld_f110",   1'b0, 3'b110, 32'h20, 32'h0, 32'h0, 0);
    applyStimulus("st_f100",   1'b1, 3'b100, 32'h20, 32'h0, 32'h0, 0);
    applyStimulus("sh_61_mis", 1'b1, 3'b001, 32'h61, 32'h1111, 32'h0, 0);
    applyStimulus("lb_62",     1'b0, 3'b000, 32'h62, 32'h0, 32'h0A7F_0000, 0);

    // Reset during REQ, then a stray ack right after reset releases
    @(negedge clk);
    req_valid  = 1'b1;
    req_write  = 1'b0;
    req_funct3 = 3'b010;
    req_addr   = 32'h80;
    mem_rdata  = 32'h7777_7777;
    mem_ack    = 1'b0;
    @(negedge clk);
    #1;
    check("rstreq_in_req", {31'd0, mem_req}, 32'd1);
    reset = 1'b1;
    @(negedge clk);
    #1;
    reset     = 1'b0;
    req_valid = 1'b0;
    mem_ack   = 1'b1;
    #1;
    check("rstreq_mem_req", {31'd0, mem_req}, 32'd0);
    check("rstreq_fault",   {31'd0, fault}, 32'd0);
    check("rstreq_rdata",   rdata, 32'd0);
    @(negedge clk);
    #1;
    mem_ack = 1'b0;
    check("rstreq_mem_req2", {31'd0, mem_req}, 32'd0);
    check("rstreq_fault2",   {31'd0, fault}, 32'd0);
    check("rstreq_rdata2",   rdata, 32'd0);
    check("rstreq_stall2",   {31'd0, stall}, 32'd0);

    applyStimulus("lw_after_rst", 1'b0, 3'b010, 32'h84, 32'h0, 32'h1357_9BDF, 0);
    check("sb_drained", sb.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Global watchdog so the bench can never hang
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
